// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues credit-limited word requests,
// buffers in-order responses with their PCs and flushes on redirect.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]          count, count_nxt;
  logic [CW-1:0]          inflight, inflight_nxt;
  logic [CW-1:0]          drop, drop_nxt;
  logic [CW-1:0]          stale;
  logic [CW:0]            credit_sum;

  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  ifq_pc     [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr, ifq_rd, ifq_wr;

  logic redirect, req_hs, pop, push;

  assign credit_sum    = {1'b0, count} + {1'b0, inflight};
  assign mem_req_valid = (state == FETCH) && (credit_sum < DEPTH_L);
  assign mem_req_addr  = fetch_pc;
  assign redirect      = redirect_valid && (state != BOOT);
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign out_valid     = (count != '0);
  assign pop           = out_valid && out_ready;
  assign push          = mem_resp_valid && (state == FETCH) && !redirect;
  assign out_instr     = fifo_instr[rd_ptr];
  assign out_pc        = fifo_pc[rd_ptr];

  // drop is only non-zero in DRAIN and inflight only in FETCH, so one sum covers both states
  assign stale = drop + inflight + CW'(req_hs) - CW'(mem_resp_valid);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    count_nxt    = count;
    inflight_nxt = inflight;
    drop_nxt     = drop;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (req_hs) fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
        inflight_nxt = inflight + CW'(req_hs) - CW'(mem_resp_valid);
        count_nxt    = count + CW'(push) - CW'(pop);
      end
      DRAIN: begin
        drop_nxt  = stale;
        state_nxt = (stale == '0) ? FETCH : DRAIN;
      end
      default: state_nxt = BOOT;
    endcase
    if (redirect) begin
      fetch_pc_nxt = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
      count_nxt    = '0;
      inflight_nxt = '0;
      drop_nxt     = stale;
      state_nxt    = (stale == '0) ? FETCH : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ifq_rd   <= '0;
      ifq_wr   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        ifq_pc[i]     <= '0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        ifq_rd <= '0;
        ifq_wr <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push) begin
          fifo_instr[wr_ptr] <= mem_resp_data;
          fifo_pc[wr_ptr]    <= ifq_pc[ifq_rd];
          wr_ptr             <= wr_ptr + PW'(1);
          ifq_rd             <= ifq_rd + PW'(1);
        end
        if (req_hs) begin
          ifq_pc[ifq_wr] <= fetch_pc;
          ifq_wr         <= ifq_wr + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: fixed-latency memory model, output scoreboard,
// redirect vector table and hand-written corner sequences.
module tb_instr_fetch_unit;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid;
  logic          redirect_valid, out_valid, out_ready;
  logic [AW-1:0] mem_req_addr, redirect_addr, out_pc;
  logic [IW-1:0] mem_resp_data, out_instr;

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .FIFO_DEPTH (4),
    .RESET_PC   (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   t;
    bit            stale;
  } mreq_t;

  typedef struct {
    logic [AW-1:0] target;
    logic [AW-1:0] exp_addr;
    int unsigned   lat;
  } vec_t;

  mreq_t         memq[$];
  logic [AW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   cyc = 0, lat = 1, hs_count = 0, pop_count = 0;
  logic [AW-1:0] exp_fetch = '0, first_pc = '0;
  bit            first_seen = 1'b0;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return a[IW-1:0] ^ 32'h5A00_0000;
  endfunction

  function automatic int unsigned stale_cnt();
    int unsigned n = 0;
    foreach (memq[i]) if (memq[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_resp();
    if (memq.size() > 0 && cyc >= memq[0].t + lat - 1) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = word_of(memq[0].addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  endtask

  // One clock: capture handshakes before the edge, update models after it.
  task automatic cycle();
    bit            hs, rsp, ohs, rdr, pend;
    logic [AW-1:0] haddr, opc, paddr, tgt, e;
    logic [IW-1:0] oins;
    mreq_t         m;
    hs    = mem_req_valid && mem_req_ready;
    haddr = mem_req_addr;
    rsp   = mem_resp_valid;
    ohs   = out_valid && out_ready;
    opc   = out_pc;
    oins  = out_instr;
    rdr   = redirect_valid;
    tgt   = redirect_addr;
    pend  = mem_req_valid && !mem_req_ready && !redirect_valid;
    paddr = mem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (ohs) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected: got pc 0x%0h expected no output", opc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", opc, e);
        chk("out_instr", 64'(oins), 64'(word_of(e)));
      end
      if (!first_seen) begin
        first_pc   = opc;
        first_seen = 1'b1;
      end
    end
    if (rsp && memq.size() > 0) m = memq.pop_front();
    if (hs) begin
      chk("req_addr", haddr, exp_fetch);
      hs_count++;
      m.addr  = haddr;
      m.t     = cyc;
      m.stale = 1'b0;
      memq.push_back(m);
      if (!rdr) begin
        exp_fetch = exp_fetch + 64'd4;
        exp_q.push_back(haddr);
      end
    end
    if (rdr) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_q.delete();
      exp_fetch = {tgt[AW-1:2], 2'b00};
    end
    if (pend) begin
      chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
      chk("req_hold_addr", mem_req_addr, paddr);
    end
    drive_resp();
  endtask

  task automatic apply_reset(input int unsigned n);
    rst            = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    redirect_valid = 1'b0;
    memq.delete();
    exp_q.delete();
    exp_fetch = 64'h0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("boot_req_valid", 64'(mem_req_valid), 64'd0);
  endtask

  task automatic redirect_to(input logic [AW-1:0] tgt, input logic [AW-1:0] exp_addr);
    int unsigned n;
    redirect_valid = 1'b1;
    redirect_addr  = tgt;
    cycle();
    first_seen = 1'b0;
    chk("redir_addr", mem_req_addr, exp_addr);
    chk("redir_out_valid", 64'(out_valid), 64'd0);
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    n = 0;
    while (stale_cnt() > 0 && n < 30) begin
      chk("drain_req_valid", 64'(mem_req_valid), 64'd0);
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(n < 30), 64'd1);
    chk("resume_req_valid", 64'(mem_req_valid), 64'd1);
    n = 0;
    while (!first_seen && n < 30) begin
      cycle();
      n++;
    end
    chk("redir_first_seen", 64'(first_seen), 64'd1);
    chk("redir_first_pc", first_pc, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    int unsigned c0, n;
    tbl[0] = '{target: 64'h0000_0000_0000_0040, exp_addr: 64'h0000_0000_0000_0040, lat: 1};
    tbl[1] = '{target: 64'h0000_0000_0000_1003, exp_addr: 64'h0000_0000_0000_1000, lat: 3};
    tbl[2] = '{target: 64'h0000_0000_8000_0006, exp_addr: 64'h0000_0000_8000_0004, lat: 2};
    tbl[3] = '{target: 64'hFFFF_FFFF_FFFF_FFFD, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC, lat: 1};
    tbl[4] = '{target: 64'h0000_0000_0000_0002, exp_addr: 64'h0000_0000_0000_0000, lat: 2};

    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    out_ready      = 1'b1;
    #2;

    // Boot and sustained streaming
    apply_reset(5);
    lat = 1;
    c0  = cyc;
    cycle();
    chk("first_req_valid", 64'(mem_req_valid), 64'd1);
    chk("first_req_addr", mem_req_addr, 64'h0);
    repeat (20) begin
      cycle();
      if (cyc - c0 == 2) chk("no_bypass_out_valid", 64'(out_valid), 64'd0);
      else if (cyc - c0 >= 3) chk("stream_out_valid", 64'(out_valid), 64'd1);
    end

    // Back-pressure: credit limit then ordered drain
    apply_reset(2);
    out_ready = 1'b0;
    hs_count  = 0;
    repeat (15) cycle();
    chk("bp_req_count", 64'(hs_count), 64'd4);
    chk("bp_req_valid", 64'(mem_req_valid), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    pop_count = 0;
    repeat (20) cycle();
    chk("bp_pop_count", 64'(pop_count), 64'd20);

    // Redirect with two requests in flight
    apply_reset(2);
    lat = 3;
    n = 0;
    while (memq.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    mem_req_ready = 1'b0;
    redirect_to(64'h1003, 64'h1000);
    repeat (10) cycle();

    // Redirect coinciding with response and pop
    apply_reset(2);
    lat       = 1;
    out_ready = 1'b0;
    n = 0;
    while (!((exp_q.size() - memq.size()) == 2 && mem_resp_valid && out_valid) && n < 20) begin
      cycle();
      n++;
    end
    chk("sim_setup_timeout", 64'(n < 20), 64'd1);
    out_ready = 1'b1;
    redirect_to(64'h40, 64'h40);
    repeat (10) cycle();

    // Memory stall with redirect during the stall
    apply_reset(2);
    repeat (6) cycle();
    mem_req_ready = 1'b0;
    repeat (6) begin
      cycle();
      chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
    end
    redirect_to(64'h203, 64'h200);
    repeat (8) cycle();

    // Redirect vector table
    for (int i = 0; i < 5; i++) begin
      lat = tbl[i].lat;
      repeat (4) cycle();
      redirect_to(tbl[i].target, tbl[i].exp_addr);
    end
    lat = 1;
    repeat (8) cycle();

    // Asynchronous reset between edges
    n = 0;
    while (!(out_valid && mem_req_valid) && n < 10) begin
      cycle();
      n++;
    end
    chk("pre_reset_active", 64'(out_valid && mem_req_valid), 64'd1);
    #2;
    apply_reset(2);
    cycle();
    chk("restart_req_valid", 64'(mem_req_valid), 64'd1);
    chk("restart_req_addr", mem_req_addr, 64'h0);
    first_seen = 1'b0;
    n = 0;
    while (!first_seen && n < 20) begin
      cycle();
      n++;
    end
    chk("restart_first_pc", first_pc, 64'h0);
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
